ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words of storage; power of two, at least 2.
REQ-002 Parameter WAIT_STATES, default 2: extra access cycles inserted per request; range 0..15.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 ram_chip_enable  input  1  request valid from the CPU memory stage.
REQ-006 ram_write_enable  input  1  1 = write, 0 = read; qualified by ram_chip_enable.
REQ-007 ram_address  input  32  byte address; word index = address[log2(DEPTH_WORDS)+1:2].
REQ-008 ram_data_input  input  32  write data from the CPU.
REQ-009 ram_sel  input  4  byte-lane enables; bit3 = data[31:24] ... bit0 = data[7:0].
REQ-010 ram_data_output  output  32  read data returned to the CPU.
REQ-011 stop_all_req_from_mem  output  1  stall request to the pipeline controller.
REQ-012 access_error  output  1  one-cycle pulse for an out-of-range or misaligned access.

Function
REQ-013 FSM states: IDLE, WAIT, DONE; the encoding is free.
REQ-014 In IDLE with ram_chip_enable=1, the block latches address, write data, sel and write_enable, then goes to WAIT if WAIT_STATES>0, else to DONE.
REQ-015 stop_all_req_from_mem is combinational: 1 in IDLE when ram_chip_enable=1, 1 throughout WAIT, 0 in DONE and in an idle IDLE.
REQ-016 WAIT counts WAIT_STATES cycles using a down-counter loaded at acceptance; it moves to DONE when the counter reaches 1.
REQ-017 Storage access occurs on the edge that enters DONE.
- Write: updates only the lanes whose ram_sel bit is 1.
- Read: registers the full word into ram_data_output; ram_sel is ignored.
REQ-018 Total stall per request is WAIT_STATES+1 cycles; DONE lasts exactly one cycle with the stall deasserted.
REQ-019 DONE always returns to IDLE, even if ram_chip_enable is still 1, so the same request is never accepted twice.
REQ-020 Latched request fields are used; input changes during WAIT are ignored, except as stated in REQ-021.
REQ-021 ram_chip_enable=0 during WAIT aborts the request.
- The FSM returns to IDLE.
- No storage write occurs and ram_data_output is unchanged.
REQ-022 ram_data_output holds its last read value until the next completed read; writes do not change it.
REQ-023 Out-of-range access (any ram_address bit above the index field set):
- Writes are dropped and reads return 0.
- access_error pulses in the DONE cycle.
- Timing is unchanged.
REQ-024 Misaligned access, all in the DONE cycle:
- Write with ram_sel=0000: no lanes written; access_error pulses.
- Read with ram_address[1:0]!=00: the word is still returned; access_error pulses.
REQ-025 Storage contents are undefined after power-up and are not cleared by reset.

Reset
REQ-026 While reset=1, all of the following hold:
- The FSM is in IDLE and the counter is 0.
- ram_data_output=0, access_error=0, stop_all_req_from_mem=0, ignoring ram_chip_enable.
REQ-027 Reset asserted mid-request aborts it: no write is committed and the FSM is in IDLE on the next cycle.

Verification
REQ-028 Write 0x12345678 to 0x00000010 with sel=1111, WAIT_STATES=2 -> stall high for 3 cycles, low in DONE; a later read of 0x10 returns 0x12345678.
REQ-029 Preload 0xAABBCCDD at 0x20, then write 0x00000011 with sel=0001 and 0x99000000 with sel=1000 -> read returns 0x99BBCC11.
REQ-030 Back-to-back requests, where ram_chip_enable stays 1 and the request changes after DONE -> each request stalls exactly WAIT_STATES+1 cycles with no double acceptance.
REQ-031 Drop ram_chip_enable in the second WAIT cycle of a write of 0xFFFFFFFF to 0x40 (old value 0x0) -> the read of 0x40 returns 0x00000000 and the FSM is back in IDLE.
REQ-032 Read 0x00010000 with DEPTH_WORDS=1024 -> ram_data_output=0 and access_error=1 for one cycle in DONE.
REQ-033 WAIT_STATES=0 read, then reset asserted on the cycle after acceptance -> ram_data_output=0 and stall=0, and the FSM is in IDLE.

Source files
------------

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder
// Description : Single-port word RAM slave for a CPU memory stage. It accepts
//               one request at a time, stalls the pipeline for a fixed number
//               of wait states, then completes the access in a one-cycle DONE
//               state. It supports byte-lane writes, registered read data and
//               out-of-range / misalignment error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ram_chip_enable,
    input  logic        ram_write_enable,
    input  logic [31:0] ram_address,
    input  logic [31:0] ram_data_input,
    input  logic [3:0]  ram_sel,
    output logic [31:0] ram_data_output,
    output logic        stop_all_req_from_mem,
    output logic        access_error
);

    localparam int         c_AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_sel;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic            w_enter_done;
    logic            w_we;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic [3:0]      w_sel;
    logic [c_AW-1:0] w_idx;
    logic            w_oor;
    logic            w_err;
    logic            w_wr_commit;

    // Select the fields of the access that completes on this edge. With zero
    // wait states DONE is entered straight from IDLE, before the request has
    // been latched, so the live inputs are used in that case.
    always_comb begin
        w_enter_done = 1'b0;
        if (r_state == S_IDLE && ram_chip_enable && c_WS == 4'd0)
            w_enter_done = 1'b1;
        else if (r_state == S_WAIT && ram_chip_enable && r_cnt == 4'd1)
            w_enter_done = 1'b1;

        if (r_state == S_IDLE) begin
            w_we    = ram_write_enable;
            w_addr  = ram_address;
            w_wdata = ram_data_input;
            w_sel   = ram_sel;
        end else begin
            w_we    = r_we;
            w_addr  = r_addr;
            w_wdata = r_wdata;
            w_sel   = r_sel;
        end

        w_idx       = w_addr[c_AW+1:2];
        w_oor       = |(w_addr >> (c_AW + 2));
        w_err       = w_oor || (w_we ? (w_sel == 4'b0000) : (w_addr[1:0] != 2'b00));
        w_wr_commit = w_enter_done && w_we && !w_oor && !reset;
    end

    // Stall the pipeline while a request is being accepted or is waiting.
    always_comb begin
        stop_all_req_from_mem = !reset &&
            ((r_state == S_IDLE && ram_chip_enable) || r_state == S_WAIT);
    end

    // Request FSM with wait-state counter, registered read data and error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_sel   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_enter_done) begin
                r_err <= w_err;
                if (!w_we)
                    r_rdata <= w_oor ? 32'd0 : r_mem[w_idx];
            end

            case (r_state)
                S_IDLE: begin
                    if (ram_chip_enable) begin
                        r_we    <= ram_write_enable;
                        r_addr  <= ram_address;
                        r_wdata <= ram_data_input;
                        r_sel   <= ram_sel;
                        if (c_WS == 4'd0) begin
                            r_state <= S_DONE;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_WS;
                        end
                    end
                end
                S_WAIT: begin
                    if (!ram_chip_enable) begin
                        // Requester withdrew: abandon without touching storage.
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Always pass through IDLE so a held enable is not re-accepted.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Byte-lane write into storage; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_sel[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    assign ram_data_output = r_rdata;
    assign access_error    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_responder
// Description : Directed self-checking bench for ram_responder. Expected read
//               data is queued when a read is issued and compared when the
//               request completes. A second instance with zero wait states
//               covers reset arriving just after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (2 wait states)
    logic        reset, ce, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        stall, err;

    // Zero-wait-state instance
    logic        rst0, ce0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  sel0;
    logic [31:0] rdata0;
    logic        stall0, err0;

    ram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut (
        .clock                 (clk),
        .reset                 (reset),
        .ram_chip_enable       (ce),
        .ram_write_enable      (we),
        .ram_address           (addr),
        .ram_data_input        (wdata),
        .ram_sel               (sel),
        .ram_data_output       (rdata),
        .stop_all_req_from_mem (stall),
        .access_error          (err)
    );

    ram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .clock                 (clk),
        .reset                 (rst0),
        .ram_chip_enable       (ce0),
        .ram_write_enable      (we0),
        .ram_address           (addr0),
        .ram_data_input        (wdata0),
        .ram_sel               (sel0),
        .ram_data_output       (rdata0),
        .stop_all_req_from_mem (stall0),
        .access_error          (err0)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int];
    logic [31:0] last_rd;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request on the main instance and check it through DONE.
    task automatic req(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic keep_ce);
        int n;
        logic oor, exp_err;
        logic [31:0] old, exp_d;
        int idx;
        oor = (a[31:12] != 20'd0);
        idx = int'(a[11:2]);
        exp_err = oor || (w ? (s == 4'b0000) : (a[1:0] != 2'b00));
        if (!w) begin
            if (oor) exp_d = 32'd0;
            else exp_d = model.exists(idx) ? model[idx] : 32'hx;
            exp_q.push_back(exp_d);
        end else if (!oor) begin
            old = model.exists(idx) ? model[idx] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (s[b]) old[8*b +: 8] = d[8*b +: 8];
            model[idx] = old;
        end
        @(negedge clk);
        ce = 1'b1; we = w; addr = a; wdata = d; sel = s;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) begin
            checks++; errors++;
            $error("FAIL %s_timeout observed=stuck expected=done", tag);
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'd3);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        if (!w) begin
            exp_d = exp_q.pop_front();
            check({tag, "_rdata"}, rdata, exp_d);
            last_rd = exp_d;
        end else begin
            check({tag, "_rdata_hold"}, rdata, last_rd);
        end
        if (!keep_ce) ce = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; we = 1'b0; addr = 0; wdata = 0; sel = 0;
        rst0 = 1'b1; ce0 = 1'b1; we0 = 1'b0; addr0 = 0; wdata0 = 0; sel0 = 0;
        last_rd = 32'd0;
        repeat (3) @(negedge clk);
        // Reset state, with chip enable held high
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst0_stall", {31'd0, stall0}, 32'd0);
        ce = 1'b0; ce0 = 1'b0;
        @(negedge clk);
        reset = 1'b0; rst0 = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'd0, stall}, 32'd0);

        // Full-word write then readback
        req("wr10", 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0);
        req("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

        // Byte-lane merge
        req("wr20", 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 1'b0);
        req("wr20b0", 1'b1, 32'h20, 32'h00000011, 4'b0001, 1'b0);
        req("wr20b3", 1'b1, 32'h20, 32'h99000000, 4'b1000, 1'b0);
        req("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        check("rd20_value", last_rd, 32'h99BBCC11);

        // Back-to-back with chip enable held through DONE
        req("bb_wr30", 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 1'b1);
        req("bb_wr34", 1'b1, 32'h34, 32'h13572468, 4'b0110, 1'b1);
        req("bb_rd30", 1'b0, 32'h30, 32'h0, 4'hF, 1'b1);
        req("bb_rd34", 1'b0, 32'h34, 32'h0, 4'h0, 1'b0);

        // Abort in the second WAIT cycle
        req("wr40", 1'b1, 32'h40, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hFFFFFFFF; sel = 4'hF;
        @(negedge clk);
        check("abort_wait1_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
        check("abort_idle_stall", {31'd0, stall}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_rdata_hold", rdata, last_rd);
        req("rd40", 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);

        // Out-of-range read, error is a single-cycle pulse
        req("rd_oor", 1'b0, 32'h00010000, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("oor_err_pulse_end", {31'd0, err}, 32'd0);
        // Out-of-range write is dropped (index 4 aliases 0x10)
        req("wr_oor", 1'b1, 32'h00001010, 32'hDEADBEEF, 4'hF, 1'b0);

        // Misaligned read and empty-lane write
        req("rd_mis", 1'b0, 32'h12, 32'h0, 4'h0, 1'b0);
        req("wr_sel0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0);
        req("rd10_after", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

        // Reset during WAIT aborts a write
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h55555555; sel = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_stall", {31'd0, stall}, 32'd0);
        check("rstmid_rdata", rdata, 32'd0);
        reset = 1'b0; ce = 1'b0; last_rd = 32'd0;
        @(negedge clk);
        req("rd10_rstmid", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

        // Zero wait states: write, read, then reset in the DONE cycle
        @(negedge clk);
        ce0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hCAFEF00D; sel0 = 4'hF;
        #1 check("z_wr_stall", {31'd0, stall0}, 32'd1);
        @(negedge clk);
        check("z_wr_done_stall", {31'd0, stall0}, 32'd0);
        ce0 = 1'b0;
        @(negedge clk);
        ce0 = 1'b1; we0 = 1'b0;
        #1 check("z_rd_stall", {31'd0, stall0}, 32'd1);
        @(negedge clk);
        check("z_rd_data", rdata0, 32'hCAFEF00D);
        check("z_rd_done_stall", {31'd0, stall0}, 32'd0);
        rst0 = 1'b1;
        @(negedge clk);
        check("z_rst_rdata", rdata0, 32'd0);
        check("z_rst_stall", {31'd0, stall0}, 32'd0);
        check("z_rst_err", {31'd0, err0}, 32'd0);
        rst0 = 1'b0; ce0 = 1'b0;
        @(negedge clk);
        check("z_idle_stall", {31'd0, stall0}, 32'd0);
        ce0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
        @(negedge clk);
        check("z_rd2_data", rdata0, 32'hCAFEF00D);
        ce0 = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always reaches its summary.
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
